// File: rtl/cla_share_arb.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among four requesters.
// Build option: define CLA_OUT_REG_EN to insert a register stage behind the adder (+1 cycle latency).

module cla32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        Cout
);
    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_g;
    logic [8:0]  grp_c;

    assign p = A ^ B;
    assign g = A & B;

    // Eight 4-bit lookahead groups; group carries resolved by a second lookahead level below.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_grp
            logic [3:0] pp;
            logic [3:0] gg;
            logic [3:0] c;

            assign pp = p[4*gi +: 4];
            assign gg = g[4*gi +: 4];

            assign grp_p[gi] = &pp;
            assign grp_g[gi] = gg[3]
                             | (pp[3] & gg[2])
                             | (pp[3] & pp[2] & gg[1])
                             | (pp[3] & pp[2] & pp[1] & gg[0]);

            assign c[0] = grp_c[gi];
            assign c[1] = gg[0] | (pp[0] & grp_c[gi]);
            assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_c[gi]);
            assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                        | (pp[2] & pp[1] & pp[0] & grp_c[gi]);

            assign S[4*gi +: 4] = pp ^ c;
        end
    endgenerate

    always_comb begin
        grp_c[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    assign Cout = grp_c[8];
endmodule

module cla_share_arb #(
    parameter int SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] op_a,
    input  logic [127:0] op_b,
    output logic [3:0]   gnt,
    output logic         rsp_valid,
    output logic [1:0]   rsp_id,
    output logic [31:0]  rsp_sum,
    output logic         rsp_cout,
    input  logic         rsp_ready,
    output logic         busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  last_reg;
    logic [1:0]  win_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        rsp_valid_reg;
    logic [1:0]  rsp_id_reg;
    logic [31:0] rsp_sum_reg;
    logic        rsp_cout_reg;

    logic [1:0]  pick;
    logic        pick_vld;
    logic [31:0] add_s;
    logic        add_c;
    logic [31:0] cap_s;
    logic        cap_c;

    cla32 u_cla (
        .A    (a_reg),
        .B    (b_reg),
        .S    (add_s),
        .Cout (add_c)
    );

`ifdef CLA_OUT_REG_EN
    // The extra stage trails the operands by one cycle, so the settle count is stretched to match.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC + 1);

    logic [31:0] s_pipe_reg;
    logic        c_pipe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pipe_reg <= '0;
            c_pipe_reg <= 1'b0;
        end else begin
            s_pipe_reg <= add_s;
            c_pipe_reg <= add_c;
        end
    end

    assign cap_s = s_pipe_reg;
    assign cap_c = c_pipe_reg;
`else
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC);

    assign cap_s = add_s;
    assign cap_c = add_c;
`endif

    // Round-robin search starting one past the last served requester.
    always_comb begin
        logic [1:0] idx;
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_reg + 2'(k);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // The grant is shown in the IDLE cycle whose closing edge commits it.
    assign gnt = (rst_n && (state_reg == IDLE) && pick_vld) ? (4'b0001 << pick) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_reg      <= 2'd3;
            win_reg       <= 2'd0;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 2'd0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_vld) begin
                        win_reg   <= pick;
                        a_reg     <= op_a[32*pick +: 32];
                        b_reg     <= op_b[32*pick +: 32];
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        rsp_sum_reg   <= cap_s;
                        rsp_cout_reg  <= cap_c;
                        rsp_id_reg    <= win_reg;
                        rsp_valid_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        last_reg      <= win_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign busy      = (state_reg != IDLE);
endmodule
